clk_div_gen: RTL



---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_gen.sv | 85 ++++++++
 2 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-enable / divided-clock generator.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Evaluated in 32 bits, so N = 2**WIDTH-1 cannot overflow for any practical WIDTH.
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_gen.sv
// Programmable divider: one-cycle tick every N clocks plus a registered divided clock.
// Divisor updates go through a pending register and only take effect at period boundaries.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_active,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             div_clk
);

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] pending_div, pending_div_next;
  logic [WIDTH-1:0] load_val;
  logic             pending, pending_next;
  logic             wrap;
  logic             apply;
  logic             tick_next;
  logic             div_clk_next;
  logic [WIDTH:0]   half_next;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    load_val         = (div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_in;
    state_next       = en ? RUN : IDLE;
    wrap             = (state == RUN) && (cnt == div_active - WIDTH'(1));
    apply            = pending && ((state == IDLE) || (wrap && en));
    div_next         = apply ? pending_div : div_active;
    pending_next     = pending;
    pending_div_next = pending_div;

    if (apply) begin
      pending_next = 1'b0;
    end
    // A load on an apply edge is kept for the next boundary; the old value is the one applied.
    if (div_load) begin
      pending_next     = 1'b1;
      pending_div_next = load_val;
    end

    cnt_next = '0;
    if ((state == RUN) && en && !wrap) begin
      cnt_next = cnt + WIDTH'(1);
    end

    tick_next    = wrap && en;
    half_next    = (WIDTH+1)'(half_ceil(32'(div_next)));
    div_clk_next = (state_next == RUN) && ({1'b0, cnt_next} < half_next);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_active  <= WIDTH'(DEFAULT_DIV);
      pending     <= 1'b0;
      pending_div <= WIDTH'(DEFAULT_DIV);
      tick        <= 1'b0;
      div_clk     <= 1'b0;
      div_ack     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      div_active  <= div_next;
      pending     <= pending_next;
      pending_div <= pending_div_next;
      tick        <= tick_next;
      div_clk     <= div_clk_next;
      div_ack     <= apply;
    end
  end

endmodule
